// File: rtl/seg_scan_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display_pkg
// Description : Shared constants for the multiplexed 7-segment scanner:
//               slot FSM state encoding, active-high "all off" patterns and
//               the hex -> segment lookup (active-high, bit order g..a).
// Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_display_pkg;

    // Per-slot FSM encoding
    localparam int unsigned     ST_W        = 1;
    localparam logic [ST_W-1:0] c_ST_BLANK  = 1'b0;
    localparam logic [ST_W-1:0] c_ST_DRIVE  = 1'b1;

    // Active-high "nothing lit" pattern; the top applies output polarity
    localparam logic [7:0]      c_SEG_OFF_AH = 8'h00;

    // Hex nibble -> active-high segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_display_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display_decode
// Description : Combinational hex nibble to active-high 7-segment decoder.
// Ports       : nibble_i [3:0]  hex digit to display
//               seg_o    [6:0]  {g,f,e,d,c,b,a}, 1 = segment lit
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_display_decode
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_display
// Description : Parametrised multiplexed 7-segment scanner. Each digit gets a
//               slot of DIV clocks; the first BLANK_CYC clocks of every slot
//               keep all anodes off to stop ghosting. Display data comes from
//               a shadow buffer reloaded only at frame start, so a frame never
//               mixes two snapshots. Supports leading-zero suppression and a
//               per-digit decimal point.
// Ports       : clk_100mhz   system clock
//               rst_n        async active-low reset
//               data         hex nibbles, data[3:0] = rightmost digit
//               dp_in        decimal point per digit, 1 = lit
//               lz_blank     1 = suppress leading zeros (digit 0 never)
//               update_en    1 = shadow reloads at frame start
//               AN           anode drives (polarity AN_ACT_LOW)
//               SEGMENT      {dp,g,f,e,d,c,b,a} (polarity SEG_ACT_LOW)
//               digit_idx    digit currently scanned
//               frame_start  one-cycle pulse at start of digit-0 slot
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned DIV         = 100000,
    parameter int unsigned BLANK_CYC   = 200,
    parameter bit          AN_ACT_LOW  = 1'b1,
    parameter bit          SEG_ACT_LOW = 1'b1,
    localparam int unsigned IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk_100mhz,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lz_blank,
    input  logic                  update_en,
    output logic [N_DIGITS-1:0]   AN,
    output logic [7:0]            SEGMENT,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_start
);

    localparam int unsigned          CNT_W        = $clog2(DIV);
    localparam logic [CNT_W-1:0]     c_CNT_MAX    = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]     c_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0]     c_DIG_MAX    = IDX_W'(N_DIGITS - 1);
    // XOR masks: applying them to an active-high pattern yields the pad
    // polarity, and they are also the "all inactive" pad value.
    localparam logic [N_DIGITS-1:0]  c_AN_OFF     = {N_DIGITS{AN_ACT_LOW}};
    localparam logic [7:0]           c_SEG_OFF    = {8{SEG_ACT_LOW}};

    // ------------------------------------------------------------------
    // Slot prescaler and digit counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0] digit_idx_q, digit_idx_d;
    logic             w_slot_wrap;
    logic             w_frame_hit;

    assign w_slot_wrap = (slot_cnt_q == c_CNT_MAX);
    assign w_frame_hit = (slot_cnt_q == '0) && (digit_idx_q == '0);

    always_comb begin
        slot_cnt_d  = w_slot_wrap ? '0 : slot_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (w_slot_wrap) begin
            digit_idx_d = (digit_idx_q == c_DIG_MAX) ? '0 : digit_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= '0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Shadow buffer: only captured on the frame-start edge
    // ------------------------------------------------------------------
    logic [4*N_DIGITS-1:0] shadow_data_q;
    logic [N_DIGITS-1:0]   shadow_dp_q;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
        end else if (w_frame_hit && update_en) begin
            shadow_data_q <= data;
            shadow_dp_q   <= dp_in;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero mask: digit i is a leading zero when every shadow
    // nibble from the top down to i is zero. Digit 0 is never masked.
    // ------------------------------------------------------------------
    logic [N_DIGITS-1:0] w_lz_mask;
    logic                w_upper_zero;

    always_comb begin
        w_lz_mask    = '0;
        w_upper_zero = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            w_upper_zero = w_upper_zero && (shadow_data_q[4*i +: 4] == 4'h0);
            w_lz_mask[i] = w_upper_zero;
        end
    end

    // ------------------------------------------------------------------
    // Segment decode of the digit currently scanned
    // ------------------------------------------------------------------
    logic [3:0] w_nibble;
    logic [6:0] w_seg_pat;

    assign w_nibble = shadow_data_q[{digit_idx_q, 2'b00} +: 4];

    seg_scan_display_decode u_decode (
        .nibble_i (w_nibble),
        .seg_o    (w_seg_pat)
    );

    // ------------------------------------------------------------------
    // BLANK/DRIVE slot FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    logic [ST_W-1:0] state_q, state_d;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // state_q always describes the current slot_cnt_q value
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_BLANK: if (slot_cnt_q == c_BLANK_LAST) state_d = c_ST_DRIVE;
            c_ST_DRIVE: if (w_slot_wrap)                state_d = c_ST_BLANK;
            default:                                    state_d = c_ST_BLANK;
        endcase
    end

    logic [N_DIGITS-1:0] an_d, w_an_ah;
    logic [7:0]          seg_d, w_seg_ah;

    always_comb begin
        w_an_ah  = '0;
        w_seg_ah = c_SEG_OFF_AH;
        if (state_q == c_ST_DRIVE) begin
            w_an_ah[digit_idx_q] = 1'b1;
            // A suppressed leading zero keeps its anode and decimal point
            w_seg_ah = {shadow_dp_q[digit_idx_q],
                        (lz_blank && w_lz_mask[digit_idx_q]) ? 7'h00 : w_seg_pat};
        end
        an_d  = w_an_ah ^ c_AN_OFF;
        seg_d = w_seg_ah ^ c_SEG_OFF;
    end

    // ------------------------------------------------------------------
    // Registered outputs (one cycle behind the counter state)
    // ------------------------------------------------------------------
    logic [N_DIGITS-1:0] an_q;
    logic [7:0]          seg_q;
    logic [IDX_W-1:0]    digit_idx_out_q;
    logic                frame_start_q;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            an_q            <= c_AN_OFF;
            seg_q           <= c_SEG_OFF;
            digit_idx_out_q <= '0;
            frame_start_q   <= 1'b0;
        end else begin
            an_q            <= an_d;
            seg_q           <= seg_d;
            digit_idx_out_q <= digit_idx_q;
            frame_start_q   <= w_frame_hit;
        end
    end

    assign AN          = an_q;
    assign SEGMENT     = seg_q;
    assign digit_idx   = digit_idx_out_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_display
// Description : Self-checking bench for seg_scan_display (N_DIGITS=4, DIV=10,
//               BLANK_CYC=2, active-low AN and SEGMENT). A reference model
//               derives every expected output from the number of clocks since
//               reset release, a frame snapshot, and the hex font table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_display;

    localparam int unsigned N     = 4;
    localparam int unsigned DIV   = 10;
    localparam int unsigned BC    = 2;
    localparam int unsigned FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic        update_en;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [1:0]  didx;
    logic        fs;

    always #5 clk = ~clk;

    seg_scan_display #(
        .N_DIGITS    (N),
        .DIV         (DIV),
        .BLANK_CYC   (BC),
        .AN_ACT_LOW  (1'b1),
        .SEG_ACT_LOW (1'b1)
    ) dut (
        .clk_100mhz  (clk),
        .rst_n       (rst_n),
        .data        (data),
        .dp_in       (dp_in),
        .lz_blank    (lz_blank),
        .update_en   (update_en),
        .AN          (an),
        .SEGMENT     (seg),
        .digit_idx   (didx),
        .frame_start (fs)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    // Active-low font (dp off)
    function automatic logic [7:0] font_al(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;
            4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;
            4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;
            4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;
            4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] ref_seg(input int unsigned d, input logic [15:0] snap,
                                           input logic [3:0] dps, input logic lz);
        logic [7:0] s;
        if (lz && d > 0 && (snap >> (4 * d)) == 16'h0) s = 8'hFF;
        else                                           s = font_al(4'((snap >> (4 * d)) & 16'hF));
        if (dps[d]) s[7] = 1'b0;
        return s;
    endfunction

    int unsigned mdl_k;        // clocks since reset release
    logic [15:0] mdl_snap;
    logic [3:0]  mdl_dps;
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg;
    logic        exp_fs;
    logic [1:0]  exp_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_k    <= 0;
            mdl_snap <= '0;
            mdl_dps  <= '0;
            exp_an   <= 4'hF;
            exp_seg  <= 8'hFF;
            exp_fs   <= 1'b0;
            exp_idx  <= '0;
        end else begin
            exp_fs  <= (mdl_k % FRAME) == 0;
            exp_idx <= 2'((mdl_k / DIV) % N);
            if ((mdl_k % DIV) < BC) begin
                exp_an  <= 4'hF;
                exp_seg <= 8'hFF;
            end else begin
                exp_an  <= ~(4'b0001 << ((mdl_k / DIV) % N));
                exp_seg <= ref_seg((mdl_k / DIV) % N, mdl_snap, mdl_dps, lz_blank);
            end
            if ((mdl_k % FRAME) == 0 && update_en) begin
                mdl_snap <= data;
                mdl_dps  <= dp_in;
            end
            mdl_k <= mdl_k + 1;
        end
    end

    // Advance n clocks, comparing all outputs 1 time unit after each edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check_val($sformatf("AN k=%0d", mdl_k), an, exp_an);
            check_val($sformatf("SEGMENT k=%0d", mdl_k), seg, exp_seg);
            check_val($sformatf("frame_start k=%0d", mdl_k), fs, exp_fs);
            check_val($sformatf("digit_idx k=%0d", mdl_k), didx, exp_idx);
        end
    endtask

    // Step until the counter sits at the given frame position, bounded
    task automatic sync_to(input int unsigned pos, input string tag);
        for (int i = 0; i < 2 * FRAME && (mdl_k % FRAME) != pos; i++) step(1);
        if ((mdl_k % FRAME) != pos) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: position %0d not reached, at %0d", tag, pos, mdl_k % FRAME);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        data      = 16'h0009;
        dp_in     = 4'h0;
        lz_blank  = 1'b0;
        update_en = 1'b1;

        // Reset held: all outputs inactive
        step(20);
        rst_n = 1'b1;

        // Plain digits, no suppression
        step(2 * FRAME);

        // Leading-zero suppression, then all-zero value
        lz_blank = 1'b1;
        step(2 * FRAME);
        data = 16'h0000;
        step(2 * FRAME);
        lz_blank = 1'b0;

        // Tearing: change data while digit 2 is being scanned
        data = 16'h1234;
        sync_to(25, "sync digit2");
        data = 16'hABCD;
        step(2 * FRAME);

        // Freeze across three frames, then re-enable with a decimal point
        update_en = 1'b0;
        repeat (12) begin
            data  = 16'($urandom);
            dp_in = 4'($urandom);
            step(DIV);
        end
        update_en = 1'b1;
        dp_in     = 4'b0100;
        step(2 * FRAME);

        // Randomised traffic
        repeat (400) begin
            if ($urandom_range(0, 1) == 0) data = 16'($urandom >> $urandom_range(0, 16));
            if ($urandom_range(0, 3) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 3) == 0) lz_blank = 1'($urandom);
            if ($urandom_range(0, 3) == 0) update_en = ($urandom_range(0, 3) != 0);
            step($urandom_range(1, 15));
        end

        // Async reset at slot_cnt=5 of digit 1
        update_en = 1'b1;
        data      = 16'h00F1;
        sync_to(15, "sync digit1 slot5");
        rst_n = 1'b0;
        #1;
        check_val("async AN", an, 4'hF);
        check_val("async SEGMENT", seg, 8'hFF);
        check_val("async digit_idx", didx, 2'd0);
        check_val("async frame_start", fs, 1'b0);
        step(3);
        rst_n = 1'b1;
        step(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
